// File: rtl/act_vector_packer.sv
// Serial-to-parallel activation packer with a two-bank valid/ready output stage.
// Optional ingest rectification is enabled by defining ACT_PACK_RELU_EN.

module act_pack_lane #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we_i,
    input  logic          wb_i,
    input  logic          rb_i,
    input  logic [DW-1:0] d_i,
    output logic [DW-1:0] q_o
);
    logic [DW-1:0] bank0_q, bank1_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bank0_q <= '0;
            bank1_q <= '0;
        end else if (we_i) begin
            if (wb_i) bank1_q <= d_i;
            else      bank0_q <= d_i;
        end
    end

    assign q_o = rb_i ? bank1_q : bank0_q;
endmodule

module act_vector_packer #(
    parameter int N_IN  = 30,
    parameter int DW    = 32,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [DW-1:0]        s_data,
    input  logic                 s_last,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [N_IN*DW-1:0]   m_data,
    output logic                 err_frame,
    output logic [CNT_W-1:0]     frame_cnt
);
    localparam int IW = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(N_IN - 1);

    logic [IW-1:0]    widx_q, widx_d;
    logic [1:0]       full_q, full_d;
    logic             wb_q, wb_d;
    logic             rb_q, rb_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [DW-1:0]    wdata;
    logic             accept, at_last, complete, early, drain;

    assign s_ready   = !full_q[wb_q];
    assign m_valid   = full_q[rb_q];
    assign err_frame = err_q;
    assign frame_cnt = cnt_q;

    assign accept   = s_valid && s_ready;
    assign at_last  = (widx_q == LAST_IDX);
    assign complete = accept && at_last;
    assign early    = accept && s_last && !at_last;
    assign drain    = m_valid && m_ready;

`ifdef ACT_PACK_RELU_EN
    // Sign bit set covers negatives and -0; both store as +0.
    assign wdata = s_data[DW-1] ? '0 : s_data;
`else
    assign wdata = s_data;
`endif

    // Completion targets an empty wb bank and drain a full rb bank, so when
    // both happen in one cycle they touch different banks.
    always_comb begin
        full_d = full_q;
        wb_d   = wb_q;
        rb_d   = rb_q;
        widx_d = widx_q;
        cnt_d  = cnt_q;
        err_d  = 1'b0;
        if (complete) begin
            full_d[wb_q] = 1'b1;
            wb_d         = !wb_q;
            widx_d       = '0;
            err_d        = !s_last;
        end else if (early) begin
            widx_d = '0;
            err_d  = 1'b1;
        end else if (accept) begin
            widx_d = widx_q + 1'b1;
        end
        if (drain) begin
            full_d[rb_q] = 1'b0;
            rb_d         = !rb_q;
            cnt_d        = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            widx_q <= '0;
            full_q <= '0;
            wb_q   <= 1'b0;
            rb_q   <= 1'b0;
            err_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            widx_q <= widx_d;
            full_q <= full_d;
            wb_q   <= wb_d;
            rb_q   <= rb_d;
            err_q  <= err_d;
            cnt_q  <= cnt_d;
        end
    end

    for (genvar k = 0; k < N_IN; k++) begin : g_lane
        act_pack_lane #(.DW(DW)) u_lane (
            .clk  (clk),
            .rst  (rst),
            .we_i (accept && (widx_q == IW'(k))),
            .wb_i (wb_q),
            .rb_i (rb_q),
            .d_i  (wdata),
            .q_o  (m_data[k*DW +: DW])
        );
    end
endmodule

// File: tb/tb_act_vector_packer.sv
// Directed bench for act_vector_packer: queue-based frame model checked every
// cycle, plus literal expectations for the documented scenarios.

module tb_act_vector_packer;
    localparam int N  = 30;
    localparam int DW = 32;
    localparam int CW = 16;

    logic            clk, rst;
    logic            s_valid, s_ready, s_last;
    logic [DW-1:0]   s_data;
    logic            m_valid, m_ready;
    logic [N*DW-1:0] m_data;
    logic            err_frame;
    logic [CW-1:0]   frame_cnt;

    int errs   = 0;
    int checks = 0;

    act_vector_packer #(.N_IN(N), .DW(DW), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .s_last    (s_last),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .err_frame (err_frame),
        .frame_cnt (frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] relu(input logic [DW-1:0] d);
`ifdef ACT_PACK_RELU_EN
        return d[DW-1] ? '0 : d;
`else
        return d;
`endif
    endfunction

    function automatic logic [DW-1:0] lane(input int k);
        return m_data[k*DW +: DW];
    endfunction

    // Model: list of completed frames awaiting delivery, at most two held.
    logic [N*DW-1:0] mq[$];
    logic [N*DW-1:0] part = '0;
    int              pidx = 0;
    logic            exp_err = 1'b0;
    logic [CW-1:0]   exp_cnt = '0;

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            mq.delete();
            part = '0; pidx = 0; exp_err = 1'b0; exp_cnt = '0;
        end else begin
            logic acc, drn;
            logic [N*DW-1:0] tmp;
            acc = s_valid && (mq.size() < 2);
            drn = (mq.size() > 0) && m_ready;
            exp_err = 1'b0;
            if (drn) begin
                tmp = mq.pop_front();
                exp_cnt = exp_cnt + 1'b1;
            end
            if (acc) begin
                part[pidx*DW +: DW] = relu(s_data);
                if (pidx == N-1) begin
                    mq.push_back(part);
                    pidx = 0;
                    exp_err = !s_last;
                end else if (s_last) begin
                    pidx = 0;
                    exp_err = 1'b1;
                end else begin
                    pidx++;
                end
            end
        end
    end

    initial forever begin
        @(negedge clk);
        chk("s_ready", s_ready, mq.size() < 2);
        chk("m_valid", m_valid, mq.size() > 0);
        chk("err_frame", err_frame, exp_err);
        chk("frame_cnt", frame_cnt, exp_cnt);
        if (mq.size() > 0)
            for (int k = 0; k < N; k++)
                chk("m_data_lane", lane(k), mq[0][k*DW +: DW]);
    end

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input logic [DW-1:0] d, input logic l);
        int n;
        n = 0;
        s_valid = 1'b1; s_data = d; s_last = l;
        while (!s_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) begin
            checks++; errs++;
            $display("FAIL send_timeout s_ready stuck low got=0 exp=1");
        end
        @(negedge clk);
        s_valid = 1'b0; s_last = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog sim time exceeded");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0; m_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_data_zero", m_data == '0, 1);
        chk("rst_frame_cnt", frame_cnt, 0);
        chk("rst_err", err_frame, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("rel_s_ready", s_ready, 1);

        // Frame of 1.0, drained immediately.
        m_ready = 1'b1;
        for (int i = 0; i < N; i++) send(32'h3F800000, i == N-1);
        chk("t1_m_valid", m_valid, 1);
        for (int k = 0; k < N; k++) chk("t1_lane", lane(k), 32'h3F800000);
        @(negedge clk);
        chk("t1_frame_cnt", frame_cnt, 1);
        chk("t1_m_valid_after", m_valid, 0);

        // Backpressure: two banks fill, third frame stalls.
        m_ready = 1'b0;
        for (int f = 1; f <= 2; f++)
            for (int k = 0; k < N; k++) send({16'(f), 16'(k)}, k == N-1);
        chk("t2_s_ready_full", s_ready, 0);
        chk("t2_hold_f1", lane(3), {16'd1, 16'd3});
        fork
            for (int k = 0; k < N; k++) send({16'd3, 16'(k)}, k == N-1);
            begin
                repeat (5) @(negedge clk);
                chk("t2_stall", s_ready, 0);
                chk("t2_still_f1", lane(7), {16'd1, 16'd7});
                m_ready = 1'b1;
                @(negedge clk);
                chk("t2_ready_back", s_ready, 1);
                chk("t2_f2_front", lane(7), {16'd2, 16'd7});
                chk("t2_cnt", frame_cnt, 2);
            end
        join
        repeat (3) @(negedge clk);
        chk("t2_cnt_final", frame_cnt, 4);

        // Early s_last on word 12, then a clean frame.
        for (int i = 0; i < 12; i++) send(32'h11110000 + i, i == 11);
        chk("t3_err", err_frame, 1);
        chk("t3_no_valid", m_valid, 0);
        @(negedge clk);
        chk("t3_err_once", err_frame, 0);
        for (int i = 0; i < N; i++) send(32'h40000000, i == N-1);
        chk("t3_valid", m_valid, 1);
        for (int k = 0; k < N; k++) chk("t3_lane", lane(k), 32'h40000000);
        @(negedge clk);

        // Missing s_last on word 30: delivered with an error pulse.
        for (int i = 0; i < N; i++) send(32'h50000000 + i, 1'b0);
        chk("t4_err", err_frame, 1);
        chk("t4_valid", m_valid, 1);
        chk("t4_lane29", lane(29), 32'h5000001D);
        @(negedge clk);
        chk("t4_err_once", err_frame, 0);

        // Async reset with bank 0 full and a partial frame at widx 17.
        m_ready = 1'b0;
        for (int i = 0; i < N; i++) send(32'h70000000 + i, i == N-1);
        for (int i = 0; i < 17; i++) send(32'h00000100 + i, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk("t5_m_valid", m_valid, 0);
        chk("t5_m_data_zero", m_data == '0, 1);
        chk("t5_frame_cnt", frame_cnt, 0);
        chk("t5_err", err_frame, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("t5_s_ready", s_ready, 1);
        chk("t5_no_valid", m_valid, 0);

        // Sign handling on ingest.
        m_ready = 1'b1;
        send(32'hBE06C5A5, 1'b0);
        send(32'h3E06C5A5, 1'b0);
        for (int i = 2; i < N; i++) send(32'h00000000, i == N-1);
`ifdef ACT_PACK_RELU_EN
        chk("t6_lane0", lane(0), 32'h00000000);
`else
        chk("t6_lane0", lane(0), 32'hBE06C5A5);
`endif
        chk("t6_lane1", lane(1), 32'h3E06C5A5);
        repeat (3) @(negedge clk);
        chk("t6_cnt", frame_cnt, 1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/act_vector_packer.md
Name: act_vector_packer

Overview:
- Producer side of the neuron-node input interface.
- Collects a serial stream of 32-bit IEEE-754 activations from a time-multiplexed previous layer.
- Packs each group of N_IN words into one flat vector. Word 0 sits at the LSBs, so lane k drives input Ak of a node.
- Presents the vector with a valid/ready handshake. Two banks let ingest of frame n+1 overlap with downstream consumption of frame n.

Parameters:
- N_IN, 30, activations per frame (node fan-in)
- DW, 32, word width (single-precision float)
- CNT_W, 16, width of the completed-frame counter

Ports:
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  reset, asynchronous, active-high
- s_valid  input  1  upstream word valid
- s_ready  output  1  packer can accept a word
- s_data  input  DW  activation word
- s_last  input  1  marks the final word of a frame
- m_valid  output  1  packed vector available
- m_ready  input  1  downstream node bank accepts the vector
- m_data  output  N_IN*DW  packed vector; lane k is bits [k*DW +: DW]
- err_frame  output  1  one-cycle pulse on a framing error
- frame_cnt  output  CNT_W  count of vectors handed downstream; wraps

Behaviour:
- Reset (asynchronous, active-high):
  - both banks cleared to 0; full[1:0]=0
  - write bank wb=0, read bank rb=0, widx=0
  - m_valid=0, m_data=0, err_frame=0, frame_cnt=0
  - s_ready=1 in the first cycle after rst deasserts
- Reset mid-frame or mid-handshake: partial frame and held vectors are discarded; no output glitch beyond the forced zeros.
- Ingest:
  - s_ready = !full[wb].
  - A word is accepted when s_valid && s_ready. It is written to bank[wb] lane widx.
  - When widx != N_IN-1, widx increments.
- Frame completion, on accept at widx == N_IN-1:
  - full[wb] set, wb toggles, widx=0.
  - If s_last=0 on this word: frame still completes and err_frame pulses.
- Early s_last, i.e. s_last=1 at widx < N_IN-1:
  - the word is accepted, the partial frame is discarded, widx=0, full unchanged, wb unchanged, err_frame pulses.
  - Stale lane contents are overwritten by the next frame.
- Output:
  - m_valid = full[rb]; m_data = bank[rb].
  - Transfer on m_valid && m_ready: full[rb] cleared, rb toggles, frame_cnt increments. frame_cnt wraps from 2^CNT_W-1 to 0.
  - m_data and m_valid are held stable while m_valid && !m_ready.
- Latency: final word accepted in cycle t gives m_valid=1 in cycle t+1 when that bank is rb. Otherwise m_valid follows once the older bank drains.
- Simultaneous completion and drain in one cycle:
  - these always target different banks, so both updates take effect.
  - s_ready in the next cycle reflects the new full[wb].
- Both banks full: s_ready=0 and upstream stalls. s_ready rises the cycle after the first drain.
- Throughput: one word per cycle sustained when m_ready is held high. No bubbles at frame boundaries.
- No arithmetic on data. Words pass bit-exact, except when the optional feature below is enabled.

Optional Feature:
- Macro: ACT_PACK_RELU_EN.
- Defined: each word is rectified on ingest. If s_data[DW-1]==1, the stored lane is all zeros; otherwise s_data is stored unchanged. Negative zero is also stored as +0.
- Undefined: words are stored unchanged and no rectification logic is built.

Test Plan:
- Reset, then stream 30 words 32'h3F800000 (1.0) with s_last on word 30 and m_ready=1 → m_valid=1 exactly one cycle after the last accept; every lane = 32'h3F800000; frame_cnt=1 after the handshake.
- m_ready=0, three back-to-back frames (lane k = k) → frames 1 and 2 fill both banks; s_ready=0 from the cycle after frame 2 completes; m_data stays frame 1 throughout. Raise m_ready → frame 1, then frame 2, delivered in order; s_ready returns 1 the cycle after the first drain.
- s_last=1 on word 12 → err_frame pulses once; no m_valid. A following clean frame of 30 words 32'h40000000 is delivered intact.
- 30 words with s_last=0 on word 30 → vector delivered and err_frame pulses once in the cycle after the 30th accept.
- Assert rst asynchronously while widx=17 and bank 0 is full → m_valid, m_data, frame_cnt, err_frame all 0 immediately; s_ready=1 after release.
- With ACT_PACK_RELU_EN, inputs 32'hBE06C5A5 and 32'h3E06C5A5 → lanes 0 and 32'h3E06C5A5. Without the macro → lanes 32'hBE06C5A5 and 32'h3E06C5A5.
